// File: rtl/alu_pkg.sv
// Shared definitions for the EXE-stage ALU: operation codes, default width
// and the status-flag bundle passed from the core to the output registers.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

  localparam alu_flags_t ALU_FLAGS_RESET = '{zero: 1'b1, negative: 1'b0,
                                            carry: 1'b0, overflow: 1'b0};

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: computes the result for AND/ADD/SUB/OR and the
// status flags derived from that same result.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  logic           add_ovf;
  logic           sub_ovf;

  // Extended by one bit so the top bit is carry-out for ADD and borrow for SUB.
  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
    sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
  end

  always_comb begin
    result         = '0;
    flags.carry    = 1'b0;
    flags.overflow = 1'b0;
    unique case (op)
      ALU_AND: result = a & b;
      ALU_ADD: begin
        result         = sum_ext[WIDTH-1:0];
        flags.carry    = sum_ext[WIDTH];
        flags.overflow = add_ovf;
      end
      ALU_SUB: begin
        result         = diff_ext[WIDTH-1:0];
        flags.carry    = diff_ext[WIDTH];
        flags.overflow = sub_ovf;
      end
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
    flags.zero     = (result == '0);
    flags.negative = result[WIDTH-1];
  end

endmodule

// File: rtl/alu.sv
// EXE-stage ALU top: registers the core result and flags with one cycle of
// latency; synchronous reset clears the result and leaves Zero set.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ALUop,
  output logic [WIDTH-1:0] Output,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
);

  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_d;
  alu_flags_t       flags_q;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (A),
    .b      (B),
    .op     (ALUop),
    .result (result_d),
    .flags  (flags_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= ALU_FLAGS_RESET;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    Output   = result_q;
    Zero     = flags_q.zero;
    Negative = flags_q.negative;
    Carry    = flags_q.carry;
    Overflow = flags_q.overflow;
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/latency
// sequences, and randomized back-to-back ops against an arithmetic model.
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  op;
  logic [15:0] out;
  logic        zero, neg, carry, ovf;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  alu #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (a),
    .B        (b),
    .ALUop    (op),
    .Output   (out),
    .Zero     (zero),
    .Negative (neg),
    .Carry    (carry),
    .Overflow (ovf)
  );

  // Packed observation: {Output[15:0], Zero, Negative, Carry, Overflow}
  function automatic logic [19:0] observe();
    return {out, zero, neg, carry, ovf};
  endfunction

  // Reference computed from integer arithmetic on unsigned/signed values.
  function automatic logic [19:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic [1:0] mop);
    int          ua = int'(ma);
    int          ub = int'(mb);
    int          sa = int'($signed(ma));
    int          sb = int'($signed(mb));
    int          r  = 0;
    logic        c  = 1'b0;
    logic        v  = 1'b0;
    logic [15:0] res;
    case (mop)
      2'd0: r = ua & ub;
      2'd1: begin
        r = ua + ub;
        c = (r > 65535);
        v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      end
      2'd2: begin
        r = ua - ub;
        c = (ua < ub);
        v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
      end
      default: r = ua | ub;
    endcase
    res = 16'(r);
    return {res, (res == 16'd0), res[15], c, v};
  endfunction

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got out=%h z=%b n=%b c=%b v=%b, expected out=%h z=%b n=%b c=%b v=%b",
               name, got[19:4], got[3], got[2], got[1], got[0],
               exp[19:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] va;
    logic [15:0] vb;
    logic [1:0]  vop;
    logic [15:0] e_out;
    logic        e_z, e_n, e_c, e_v;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [19:0] exp_q;

    vecs.push_back('{"regb_and", 16'd15,    16'hFFF6, ALU_AND, 16'h0006, 0, 0, 0, 0});
    vecs.push_back('{"regb_add", 16'd15,    16'hFFF6, ALU_ADD, 16'h0005, 0, 0, 1, 0});
    vecs.push_back('{"regb_sub", 16'd15,    16'hFFF6, ALU_SUB, 16'd25,   0, 0, 1, 0});
    vecs.push_back('{"imm_and",  16'd15,    16'd5,    ALU_AND, 16'd5,    0, 0, 0, 0});
    vecs.push_back('{"imm_add",  16'd15,    16'd5,    ALU_ADD, 16'd20,   0, 0, 0, 0});
    vecs.push_back('{"imm_sub",  16'd15,    16'd5,    ALU_SUB, 16'd10,   0, 0, 0, 0});
    vecs.push_back('{"imm_or",   16'd15,    16'd5,    ALU_OR,  16'd15,   0, 0, 0, 0});
    vecs.push_back('{"add_povf", 16'h7FFF,  16'h0001, ALU_ADD, 16'h8000, 0, 1, 0, 1});
    vecs.push_back('{"add_wrap", 16'hFFFF,  16'h0001, ALU_ADD, 16'h0000, 1, 0, 1, 0});
    vecs.push_back('{"sub_novf", 16'h8000,  16'h0001, ALU_SUB, 16'h7FFF, 0, 0, 0, 1});
    vecs.push_back('{"sub_brw",  16'h0000,  16'h0001, ALU_SUB, 16'hFFFF, 0, 1, 1, 0});
    vecs.push_back('{"or_neg",   16'hFFFF,  16'h0000, ALU_OR,  16'hFFFF, 0, 1, 0, 0});
    vecs.push_back('{"and_zero", 16'h0000,  16'hFFFF, ALU_AND, 16'h0000, 1, 0, 0, 0});
    vecs.push_back('{"add_both", 16'h8000,  16'h8000, ALU_ADD, 16'h0000, 1, 0, 1, 1});

    rst = 1'b1; a = 16'h1234; b = 16'h4321; op = ALU_OR;
    @(posedge clk); #1;
    check("reset_state", observe(), {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});

    // Reset overrides an op presented in the same cycle, then ADD resumes.
    a = 16'd1; b = 16'd1; op = ALU_ADD;
    @(posedge clk); #1;
    check("reset_override", observe(), {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_release", observe(), {16'd2, 1'b0, 1'b0, 1'b0, 1'b0});

    // Table vectors, applied back-to-back on consecutive edges.
    for (int i = 0; i < vecs.size(); i++) begin
      a = vecs[i].va; b = vecs[i].vb; op = vecs[i].vop;
      @(posedge clk); #1;
      check(vecs[i].name, observe(),
            {vecs[i].e_out, vecs[i].e_z, vecs[i].e_n, vecs[i].e_c, vecs[i].e_v});
    end

    // Latency: changing inputs mid-cycle must not move the registered output.
    a = 16'd15; b = 16'd5; op = ALU_ADD;
    @(posedge clk); #1;
    check("lat_first", observe(), {16'd20, 1'b0, 1'b0, 1'b0, 1'b0});
    #2 op = ALU_SUB;
    #1;
    check("lat_hold", observe(), {16'd20, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    check("lat_update", observe(), {16'd10, 1'b0, 1'b0, 1'b0, 1'b0});

    // Randomized back-to-back stream against the model.
    for (int i = 0; i < 300; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      op = 2'($urandom_range(0, 3));
      if (i % 10 == 0) b = a;
      exp_q = model(a, b, op);
      @(posedge clk); #1;
      check($sformatf("rand_%0d", i), observe(), exp_q);
    end

    // Mid-stream reset clears the pipeline register for exactly one cycle.
    a = 16'h7FFF; b = 16'h0001; op = ALU_ADD; rst = 1'b1;
    @(posedge clk); #1;
    check("midrst", observe(), {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_release", observe(), model(16'h7FFF, 16'h0001, ALU_ADD));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
